// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor
// Receive-side checker for a slow divided clock. Brings slow_in into the clk
// domain, emits one-cycle edge pulses, measures each half-period in clk cycles,
// and flags intervals that are off-frequency or edges that stop arriving.
module slow_clk_monitor #(
   parameter int CNT_W    = 27,
   parameter int EXP_HALF = 50_000_000,
   parameter int TOL      = 1000,
   parameter int TIMEOUT  = 100_000_000,
   parameter int TICK_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              slow_in,
   input  logic              en,
   input  logic              clr,
   output logic              rise_pulse,
   output logic              fall_pulse,
   output logic [CNT_W-1:0]  half_period,
   output logic              period_valid,
   output logic              freq_err,
   output logic              stalled,
   output logic [TICK_W-1:0] tick_count
);

   // Saturation point of the interval counter; reaching it means the input stalled.
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   // Reference values for the tolerance check, two bits wider than the counter so
   // the signed difference can never overflow.
   localparam logic signed [CNT_W+1:0] EXP_S = (CNT_W+2)'(EXP_HALF);
   localparam logic signed [CNT_W+1:0] TOL_S = (CNT_W+2)'(TOL);

   // Three-flop chain: s1/s2 resolve metastability, s3 is the previous level.
   logic s1;
   logic s2;
   logic s3;

   logic edge_det;
   logic rise_det;
   logic fall_det;

   // Cycles elapsed since the last edge cycle, minus one.
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] interval;

   // Set by any edge; a measurement is only trusted if a previous edge armed it.
   logic armed;

   // Counter step that sticks at the timeout value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v >= TIMEOUT_C) begin
         r = TIMEOUT_C;
      end else begin
         r = v + CNT_W'(1);
      end
      return r;
   endfunction

   // True when |iv - EXP_HALF| exceeds TOL; a deviation of exactly TOL passes.
   function automatic logic out_of_tol(input logic [CNT_W-1:0] iv);
      logic signed [CNT_W+1:0] diff;
      diff = $signed({2'b00, iv}) - EXP_S;
      if (diff[CNT_W+1]) begin
         diff = -diff;
      end
      return (diff > TOL_S);
   endfunction

   // Synchroniser chain; keeps running even when the monitor is disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= slow_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Edge decode from the synchronised levels and the interval ending on this edge.
   always_comb begin
      edge_det = s2 ^ s3;
      rise_det = s2 & ~s3;
      fall_det = ~s2 & s3;
      interval = hcnt + CNT_W'(1);
   end

   // Edge pulses, interval counting, measurement capture, frequency and stall flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
         period_valid <= 1'b0;
         half_period  <= '0;
         freq_err     <= 1'b0;
         stalled      <= 1'b0;
         hcnt         <= '0;
         armed        <= 1'b0;
      end else begin
         rise_pulse   <= en & rise_det;
         fall_pulse   <= en & fall_det;
         period_valid <= 1'b0;

         // A set from a measurement below overrides a clear in the same cycle.
         if (clr) begin
            freq_err <= 1'b0;
         end

         if (!en) begin
            hcnt    <= '0;
            armed   <= 1'b0;
            stalled <= 1'b0;
         end else if (edge_det) begin
            hcnt    <= '0;
            armed   <= 1'b1;
            stalled <= 1'b0;
            // The edge that ends a stall only re-arms; its interval is meaningless.
            if (armed && !stalled) begin
               half_period  <= interval;
               period_valid <= 1'b1;
               if (out_of_tol(interval)) begin
                  freq_err <= 1'b1;
               end
            end
         end else begin
            hcnt <= sat_inc(hcnt);
            if (hcnt == TIMEOUT_C) begin
               stalled <= 1'b1;
            end
         end
      end
   end

   // Rising-edge tick counter; a clear coinciding with a tick wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_count <= '0;
      end else if (clr) begin
         tick_count <= '0;
      end else if (en && rise_pulse) begin
         tick_count <= tick_count + TICK_W'(1);
      end
   end

endmodule

// File: tb/tb_slow_clk_monitor.sv
// tb_slow_clk_monitor
// Directed bench for slow_clk_monitor with a small configuration. Expected
// measurements and tick values are queued when slow_in is toggled and compared
// when the DUT reports them.
module tb_slow_clk_monitor;

   localparam int CNT_W    = 8;
   localparam int EXP_HALF = 10;
   localparam int TOL      = 1;
   localparam int TIMEOUT  = 40;
   localparam int TICK_W   = 4;

   logic              clk;
   logic              rst_n;
   logic              slow_in;
   logic              en;
   logic              clr;
   logic              rise_pulse;
   logic              fall_pulse;
   logic [CNT_W-1:0]  half_period;
   logic              period_valid;
   logic              freq_err;
   logic              stalled;
   logic [TICK_W-1:0] tick_count;

   typedef struct {
      logic [CNT_W-1:0] hp;
      logic             fe;
   } meas_t;

   meas_t             meas_q[$];
   logic [TICK_W-1:0] tick_q[$];

   int n_cmp     = 0;
   int n_bad     = 0;
   int since     = 0;
   int exp_falls = 0;
   int act_falls = 0;

   logic              b_armed  = 1'b0;
   logic              b_fe     = 1'b0;
   logic              en_model = 1'b0;
   logic [TICK_W-1:0] b_tick   = '0;

   slow_clk_monitor #(
      .CNT_W    (CNT_W),
      .EXP_HALF (EXP_HALF),
      .TOL      (TOL),
      .TIMEOUT  (TIMEOUT),
      .TICK_W   (TICK_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .slow_in      (slow_in),
      .en           (en),
      .clr          (clr),
      .rise_pulse   (rise_pulse),
      .fall_pulse   (fall_pulse),
      .half_period  (half_period),
      .period_valid (period_valid),
      .freq_err     (freq_err),
      .stalled      (stalled),
      .tick_count   (tick_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         since++;
      end
   endtask

   // Toggle slow_in and queue whatever the DUT should report for this edge.
   task automatic edge_now();
      int    len;
      meas_t m;
      slow_in = ~slow_in;
      if (en_model) begin
         len = since;
         if (b_armed && len <= TIMEOUT + 1) begin
            if (len > EXP_HALF + TOL || len < EXP_HALF - TOL) b_fe = 1'b1;
            m.hp = CNT_W'(len);
            m.fe = b_fe;
            meas_q.push_back(m);
         end
         b_armed = 1'b1;
         if (slow_in) begin
            b_tick = TICK_W'(b_tick + 1);
            tick_q.push_back(b_tick);
         end else begin
            exp_falls++;
         end
      end
      since = 0;
   endtask

   task automatic tog(input int n);
      edge_now();
      cyc(n);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      b_fe   = 1'b0;
      b_tick = '0;
   endtask

   // Output monitor: pops the scoreboard when the DUT reports a tick or a measurement.
   initial begin
      logic              rise_d;
      logic              fall_d;
      meas_t             m;
      logic [TICK_W-1:0] t;
      rise_d = 1'b0;
      fall_d = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rise_d = 1'b0;
            fall_d = 1'b0;
         end else begin
            if (rise_d) begin
               check("rise_width", rise_pulse, 0);
               check("tick_expected", tick_q.size() > 0, 1);
               if (tick_q.size() > 0) begin
                  t = tick_q.pop_front();
                  check("tick_count", tick_count, t);
               end
            end
            if (fall_d) check("fall_width", fall_pulse, 0);
            if (fall_pulse) act_falls++;
            if (period_valid) begin
               check("pv_expected", meas_q.size() > 0, 1);
               if (meas_q.size() > 0) begin
                  m = meas_q.pop_front();
                  check("half_period", half_period, m.hp);
                  check("freq_err_meas", freq_err, m.fe);
               end
            end
            rise_d = rise_pulse;
            fall_d = fall_pulse;
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      slow_in = 1'b0;
      en      = 1'b0;
      clr     = 1'b0;
      cyc(2);
      check("rst_rise", rise_pulse, 0);
      check("rst_fall", fall_pulse, 0);
      check("rst_hp", half_period, 0);
      check("rst_pv", period_valid, 0);
      check("rst_fe", freq_err, 0);
      check("rst_stalled", stalled, 0);
      check("rst_tick", tick_count, 0);
      rst_n    = 1'b1;
      en       = 1'b1;
      en_model = 1'b1;
      cyc(2);

      // Nominal toggling
      for (int i = 0; i < 6; i++) tog(10);
      check("t1_hp", half_period, 10);
      check("t1_fe", freq_err, 0);
      check("t1_tick", tick_count, 3);

      // Off-frequency, sticky error, clear, boundary
      for (int i = 0; i < 4; i++) tog(12);
      check("t2_fe_set", freq_err, 1);
      for (int i = 0; i < 4; i++) tog(10);
      check("t2_fe_sticky", freq_err, 1);
      do_clr();
      check("t2_fe_clr", freq_err, 0);
      check("t2_tick_clr", tick_count, 0);
      for (int i = 0; i < 4; i++) tog(11);
      check("t2_fe_boundary", freq_err, 0);
      check("t2_hp_11", half_period, 11);

      // Stall detection and recovery
      edge_now();
      cyc(43);
      check("t3_stall_early", stalled, 0);
      cyc(1);
      check("t3_stall_set", stalled, 1);
      cyc(1);
      check("t3_stall_held", stalled, 1);
      edge_now();
      cyc(3);
      check("t3_stall_clear", stalled, 0);
      cyc(7);
      tog(10);
      tog(10);
      check("t3_hp_after", half_period, 10);

      // Tick wrap and clear coinciding with a rise
      if (slow_in) tog(10);
      do_clr();
      for (int i = 0; i < 34; i++) tog(10);
      check("t4_wrap", tick_count, 1);
      edge_now();
      cyc(3);
      check("t4_rise_now", rise_pulse, 1);
      void'(tick_q.pop_back());
      tick_q.push_back('0);
      clr = 1'b1;
      cyc(1);
      clr    = 1'b0;
      b_tick = '0;
      b_fe   = 1'b0;
      cyc(6);
      check("t4_clr_rise", tick_count, 0);
      tog(10);

      // Monitor disabled while toggling
      edge_now();
      cyc(5);
      en       = 1'b0;
      en_model = 1'b0;
      b_armed  = 1'b0;
      cyc(5);
      tog(10);
      tog(10);
      check("t5_hp_kept", half_period, 10);
      check("t5_stalled", stalled, 0);
      edge_now();
      cyc(5);
      en       = 1'b1;
      en_model = 1'b1;
      cyc(5);
      check("t5_tick_frozen", tick_count, b_tick);
      check("t5_falls", act_falls, exp_falls);
      tog(10);
      tog(10);
      tog(10);
      check("t5_hp_after", half_period, 10);

      // Asynchronous reset mid-period
      for (int i = 0; i < 3; i++) tog(13);
      if (slow_in) tog(10);
      check("t6_fe_pre", freq_err, 1);
      cyc(5);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_rise", rise_pulse, 0);
      check("t6_fall", fall_pulse, 0);
      check("t6_hp", half_period, 0);
      check("t6_pv", period_valid, 0);
      check("t6_fe", freq_err, 0);
      check("t6_stalled", stalled, 0);
      check("t6_tick", tick_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      meas_q.delete();
      tick_q.delete();
      b_armed = 1'b0;
      b_fe    = 1'b0;
      b_tick  = '0;
      cyc(3);
      for (int i = 0; i < 4; i++) tog(10);
      check("t6_hp_after", half_period, 10);
      check("t6_tick_after", tick_count, b_tick);

      check("end_meas_q", meas_q.size(), 0);
      check("end_tick_q", tick_q.size(), 0);
      check("end_falls", act_falls, exp_falls);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
